mem_access_unit: RTL and testbench

Memory-stage access controller. It sits directly downstream of the EXE→MEM pipeline register and performs the load or store carried by the held instruction over a request/acknowledge memory port. Byte stores are implemented as read-modify-write. It drives `freeze` back to the pipeline registers until the access completes, then presents load data for the MEM→WB register.

---
 rtl/mem_pkg.sv | 51 +++++
 rtl/mem_byte_lane.sv | 21 ++
 rtl/mem_access_unit.sv | 136 +++++++++++++
 tb/tb_mem_access_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg : shared state encoding and byte-lane helpers for mem_access_unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RMW_RD = 3'd2,
        S_WR     = 3'd3,
        S_DONE   = 3'd4
    } mem_state_t;

    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

    // Little-endian: lane 0 occupies bits [7:0].
    function automatic logic [31:0] byte_merge(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  byte_val);
        logic [31:0] merged;
        merged = word;
        case (lane)
            LANE_0:  merged[7:0]   = byte_val;
            LANE_1:  merged[15:8]  = byte_val;
            LANE_2:  merged[23:16] = byte_val;
            default: merged[31:24] = byte_val;
        endcase
        return merged;
    endfunction

    function automatic logic [31:0] byte_extract_sext(input logic [31:0] word,
                                                      input logic [1:0]  lane);
        logic [7:0] sel;
        case (lane)
            LANE_0:  sel = word[7:0];
            LANE_1:  sel = word[15:8];
            LANE_2:  sel = word[23:16];
            default: sel = word[31:24];
        endcase
        return {{24{sel[7]}}, sel};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_byte_lane.sv
// ---------------------------------------------------------------------------
// mem_byte_lane : combinational byte merge (SB) and sign-extended extract (LB)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_byte_lane (
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [7:0]  byte_in,
    output logic [31:0] merged,
    output logic [31:0] extracted
);
    import mem_pkg::*;

    assign merged    = byte_merge(word, lane, byte_in);
    assign extracted = byte_extract_sext(word, lane);

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit : MEM-stage load/store controller with byte-store RMW
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_write,
    input  logic              mem_to_reg,
    input  logic              is_LB_SB,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [31:0]       val2,
    input  logic              cache_en,
    input  logic              halted,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_cacheable,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              freeze,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              misaligned
);
    import mem_pkg::*;

    mem_state_t        r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_mem_cacheable;
    logic [31:0]       r_load_data;
    logic              r_load_valid;

    logic              w_op_start;
    logic              w_start;
    logic              w_busy;
    logic [31:0]       w_merged;
    logic [31:0]       w_extracted;

    assign w_op_start = (mem_write | mem_to_reg) & ~halted;
    assign w_start    = (r_state == S_IDLE) & w_op_start;
    assign w_busy     = (r_state == S_RD) | (r_state == S_RMW_RD) | (r_state == S_WR);

    // Cycle-0 stall must be visible before the first edge, so freeze is combinational.
    assign freeze     = ~rst & (w_start | w_busy);
    assign misaligned = ~rst & w_start & ~is_LB_SB & (alu_result[1:0] != 2'b00);

    mem_byte_lane u_byte_lane (
        .word      (mem_rdata),
        .lane      (alu_result[1:0]),
        .byte_in   (val2[7:0]),
        .merged    (w_merged),
        .extracted (w_extracted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_mem_req       <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_mem_cacheable <= 1'b0;
            r_load_data     <= '0;
            r_load_valid    <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_op_start) begin
                        r_mem_req       <= 1'b1;
                        r_mem_addr      <= {alu_result[ADDR_W-1:2], 2'b00};
                        r_mem_cacheable <= cache_en;
                        // A store wins when both store and load flags are set.
                        if (mem_write) begin
                            if (is_LB_SB) begin
                                r_state <= S_RMW_RD;
                            end else begin
                                r_state     <= S_WR;
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= val2;
                            end
                        end else begin
                            r_state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (mem_ack) begin
                        r_state         <= S_DONE;
                        r_mem_req       <= 1'b0;
                        r_mem_cacheable <= 1'b0;
                        r_load_valid    <= 1'b1;
                        r_load_data     <= is_LB_SB ? w_extracted : mem_rdata;
                    end
                end
                S_RMW_RD: begin
                    if (mem_ack) begin
                        r_state     <= S_WR;
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= w_merged;
                    end
                end
                S_WR: begin
                    if (mem_ack) begin
                        r_state         <= S_DONE;
                        r_mem_req       <= 1'b0;
                        r_mem_we        <= 1'b0;
                        r_mem_cacheable <= 1'b0;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req       = r_mem_req;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign mem_cacheable = r_mem_cacheable;
    assign load_data     = r_load_data;
    assign load_valid    = r_load_valid;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit : directed self-checking bench for mem_access_unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_write, mem_to_reg, is_LB_SB, cache_en, halted;
    logic [31:0] alu_result, val2;
    logic        mem_req, mem_we, mem_cacheable;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, load_data;
    logic        mem_ack, freeze, load_valid, misaligned;

    int n_asserts = 0;
    int n_fail    = 0;
    int frz_cnt   = 0;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .is_LB_SB      (is_LB_SB),
        .alu_result    (alu_result),
        .val2          (val2),
        .cache_en      (cache_en),
        .halted        (halted),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_cacheable (mem_cacheable),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .freeze        (freeze),
        .load_data     (load_data),
        .load_valid    (load_valid),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic r, input logic b,
                         input logic [31:0] addr, input logic [31:0] v2);
        mem_write  = w;
        mem_to_reg = r;
        is_LB_SB   = b;
        alu_result = addr;
        val2       = v2;
        cache_en   = 1'b1;
        halted     = 1'b0;
    endtask

    task automatic clear_instr();
        issue(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cache_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_instr();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        cyc(); cyc();
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_freeze", freeze, 0);
        check("rst_lvalid", load_valid, 0);
        check("rst_misal", misaligned, 0);
        check("rst_cache", mem_cacheable, 0);
        check("rst_ldata", load_data, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        rst = 1'b0;

        // LW 0x10, ack in first request cycle
        cyc();
        issue(1'b0, 1'b1, 1'b0, 32'h10, 32'h0); #1;
        check("lw_c0_freeze", freeze, 1);
        check("lw_c0_req", mem_req, 0);
        check("lw_c0_misal", misaligned, 0);
        cyc();
        check("lw_c1_req", mem_req, 1);
        check("lw_c1_we", mem_we, 0);
        check("lw_c1_addr", mem_addr, 32'h10);
        check("lw_c1_cache", mem_cacheable, 1);
        check("lw_c1_freeze", freeze, 1);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        cyc();
        mem_ack = 1'b0;
        check("lw_done_freeze", freeze, 0);
        check("lw_done_lvalid", load_valid, 1);
        check("lw_done_ldata", load_data, 32'hDEAD_BEEF);
        check("lw_done_req", mem_req, 0);

        // LB 0x13 back-to-back, instruction held through DONE above
        cyc();
        issue(1'b0, 1'b1, 1'b1, 32'h13, 32'h0); #1;
        check("lb3_lvalid_idle", load_valid, 0);
        check("lb3_c0_freeze", freeze, 1);
        check("lb3_c0_misal", misaligned, 0);
        cyc();
        check("lb3_c1_addr", mem_addr, 32'h10);
        mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
        cyc();
        mem_ack = 1'b0;
        check("lb3_lvalid", load_valid, 1);
        check("lb3_ldata", load_data, 32'hFFFF_FF80);

        // LB 0x11
        cyc();
        issue(1'b0, 1'b1, 1'b1, 32'h11, 32'h0);
        cyc();
        mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
        cyc();
        mem_ack = 1'b0;
        check("lb1_ldata", load_data, 32'h0000_0012);

        // SB 0x22, val2 0xAB, old word 0x11223344
        cyc();
        issue(1'b1, 1'b0, 1'b1, 32'h22, 32'h0000_00AB); #1;
        check("sb_c0_freeze", freeze, 1);
        cyc();
        check("sb_rd_req", mem_req, 1);
        check("sb_rd_we", mem_we, 0);
        check("sb_rd_addr", mem_addr, 32'h20);
        check("sb_rd_freeze", freeze, 1);
        mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
        cyc();
        mem_rdata = 32'h0;
        check("sb_wr_we", mem_we, 1);
        check("sb_wr_wdata", mem_wdata, 32'h11AB_3344);
        check("sb_wr_addr", mem_addr, 32'h20);
        check("sb_wr_freeze", freeze, 1);
        cyc();
        mem_ack = 1'b0;
        check("sb_done_freeze", freeze, 0);
        check("sb_done_req", mem_req, 0);
        check("sb_done_lvalid", load_valid, 0);

        // SW with 3 wait cycles
        cyc();
        issue(1'b1, 1'b0, 1'b0, 32'h40, 32'hCAFE_F00D); #1;
        frz_cnt = int'(freeze);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("sw_wait_req", mem_req, 1);
            check("sw_wait_we", mem_we, 1);
            check("sw_wait_addr", mem_addr, 32'h40);
            check("sw_wait_wdata", mem_wdata, 32'hCAFE_F00D);
            frz_cnt += int'(freeze);
        end
        cyc();
        check("sw_ack_req", mem_req, 1);
        frz_cnt += int'(freeze);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        frz_cnt += int'(freeze);
        check("sw_done_req", mem_req, 0);
        check("sw_freeze_cycles", frz_cnt, 5);
        cyc();
        clear_instr(); #1;
        check("sw_after_freeze", freeze, 0);
        check("sw_after_req", mem_req, 0);

        // Reset during RD; late ack must be ignored
        cyc();
        issue(1'b0, 1'b1, 1'b0, 32'h30, 32'h0);
        cyc();
        check("rrd_req", mem_req, 1);
        rst = 1'b1;
        clear_instr();
        cyc();
        rst = 1'b0; #1;
        check("rrd_req_drop", mem_req, 0);
        check("rrd_freeze", freeze, 0);
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        cyc();
        mem_ack = 1'b0;
        check("rrd_ack_lvalid", load_valid, 0);
        check("rrd_ack_req", mem_req, 0);
        check("rrd_ack_ldata", load_data, 32'h0);

        // Halt marker suppresses the access
        issue(1'b0, 1'b1, 1'b0, 32'h50, 32'h0);
        halted = 1'b1; #1;
        check("halt_freeze", freeze, 0);
        cyc();
        check("halt_req", mem_req, 0);
        check("halt_freeze2", freeze, 0);
        clear_instr();

        // Misaligned LW 0x06
        cyc();
        issue(1'b0, 1'b1, 1'b0, 32'h06, 32'h0); #1;
        check("mis_c0_misal", misaligned, 1);
        check("mis_c0_freeze", freeze, 1);
        cyc();
        check("mis_c1_misal", misaligned, 0);
        check("mis_c1_addr", mem_addr, 32'h04);
        mem_ack = 1'b1; mem_rdata = 32'h0123_4567;
        cyc();
        mem_ack = 1'b0;
        check("mis_ldata", load_data, 32'h0123_4567);
        check("mis_lvalid", load_valid, 1);
        cyc();
        clear_instr();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
